sobel_stream: RTL



---
 rtl/sobel_stream_if.sv | 25 ++
 rtl/sobel_stream.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_if.sv
// Stream bundle for sobel_stream: raster pixel input and gradient pixel output,
// each with its own valid/ready handshake.
interface sobel_stream_if #(
  parameter int PIXEL_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [PIXEL_W-1:0] in_data;
  logic               in_sof;
  logic               out_valid;
  logic               out_ready;
  logic [PIXEL_W-1:0] out_data;
  logic               out_sof;
  logic               out_eol;

  modport slave (
    input  in_valid, in_data, in_sof, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eol
  );

  modport master (
    output in_valid, in_data, in_sof, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eol
  );
endinterface

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: two line buffers feed a sliding window,
// then a stallable three-stage pipeline emits one gradient per interior pixel.
module sobel_stream #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int PIXEL_W      = 8,
  parameter int SHIFT        = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic [PIXEL_W-1:0] threshold,
  sobel_stream_if.slave      strm
);
  localparam int GW = PIXEL_W + 3;
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam logic [CW-1:0]      COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0]      ROW_LAST = RW'(IMAGE_HEIGHT - 1);
  localparam logic [PIXEL_W-1:0] PIX_MAX  = '1;

  logic en, accept;

  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d, row_cur;
  logic [1:0]         mode_q, mode_d, mode1_q;
  logic [PIXEL_W-1:0] thr_q, thr_d, thr1_q;

  logic [PIXEL_W-1:0] lb_old [IMAGE_WIDTH];
  logic [PIXEL_W-1:0] lb_new [IMAGE_WIDTH];
  logic [PIXEL_W-1:0] rd_old, rd_new;

  logic [PIXEL_W-1:0] top_q [3];
  logic [PIXEL_W-1:0] mid_q [3];
  logic [PIXEL_W-1:0] bot_q [3];
  logic v0_q, sof0_q, eol0_q;
  logic v0_d, sof0_d, eol0_d;

  logic signed [GW-1:0] gx_q, gy_q, gx_d, gy_d;
  logic v1_q, sof1_q, eol1_q;

  logic [GW-1:0]      ax, ay, sum;
  logic [PIXEL_W-1:0] out_data_q, out_data_d;
  logic               out_valid_q, out_sof_q, out_eol_q;

  function automatic logic [GW-1:0] widen(input logic [PIXEL_W-1:0] p);
    return GW'(p);
  endfunction

  function automatic logic [GW-1:0] mag(input logic signed [GW-1:0] g);
    return g[GW-1] ? GW'(-g) : GW'(g);
  endfunction

  function automatic logic [PIXEL_W-1:0] shift_sat(input logic [GW-1:0] v);
    logic [GW-1:0] s;
    s = v >> SHIFT;
    return (s > GW'(PIX_MAX)) ? PIX_MAX : s[PIXEL_W-1:0];
  endfunction

  // The whole block freezes whenever a presented output is not being taken.
  assign en     = !out_valid_q || strm.out_ready;
  assign accept = strm.in_valid && en;

  assign rd_old = lb_old[col_cur];
  assign rd_new = lb_new[col_cur];

  // An in_sof pixel is forced to (0,0), which also resyncs a frame mid-line.
  always_comb begin
    col_cur = strm.in_sof ? '0 : col_q;
    row_cur = strm.in_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    mode_d  = mode_q;
    thr_d   = thr_q;
    v0_d    = 1'b0;
    sof0_d  = 1'b0;
    eol0_d  = 1'b0;
    if (accept) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
        row_d = row_cur;
      end
      if (strm.in_sof) begin
        mode_d = mode;
        thr_d  = threshold;
      end
      v0_d   = (row_cur >= RW'(2)) && (col_cur >= CW'(2));
      sof0_d = (row_cur == RW'(2)) && (col_cur == CW'(2));
      eol0_d = v0_d && (col_cur == COL_LAST);
    end
  end

  always_comb begin
    gx_d = signed'((widen(top_q[2]) + (widen(mid_q[2]) << 1) + widen(bot_q[2]))
                 - (widen(top_q[0]) + (widen(mid_q[0]) << 1) + widen(bot_q[0])));
    gy_d = signed'((widen(bot_q[0]) + (widen(bot_q[1]) << 1) + widen(bot_q[2]))
                 - (widen(top_q[0]) + (widen(top_q[1]) << 1) + widen(top_q[2])));
  end

  always_comb begin
    ax  = mag(gx_q);
    ay  = mag(gy_q);
    sum = ax + ay;
    case (mode1_q)
      2'd1:    out_data_d = shift_sat(ax);
      2'd2:    out_data_d = shift_sat(ay);
      2'd3:    out_data_d = (shift_sat(sum) >= thr1_q) ? PIX_MAX : '0;
      default: out_data_d = shift_sat(sum);
    endcase
  end

  // Mode and threshold travel with the pixel so a new frame's settings never
  // touch the tail of the previous frame still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= '0;
      thr_q       <= '0;
      for (int i = 0; i < 3; i++) begin
        top_q[i] <= '0;
        mid_q[i] <= '0;
        bot_q[i] <= '0;
      end
      v0_q        <= 1'b0;
      sof0_q      <= 1'b0;
      eol0_q      <= 1'b0;
      gx_q        <= '0;
      gy_q        <= '0;
      v1_q        <= 1'b0;
      sof1_q      <= 1'b0;
      eol1_q      <= 1'b0;
      mode1_q     <= '0;
      thr1_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
    end else if (en) begin
      col_q  <= col_d;
      row_q  <= row_d;
      mode_q <= mode_d;
      thr_q  <= thr_d;
      if (accept) begin
        top_q[0] <= top_q[1];
        top_q[1] <= top_q[2];
        top_q[2] <= rd_old;
        mid_q[0] <= mid_q[1];
        mid_q[1] <= mid_q[2];
        mid_q[2] <= rd_new;
        bot_q[0] <= bot_q[1];
        bot_q[1] <= bot_q[2];
        bot_q[2] <= strm.in_data;
      end
      v0_q        <= v0_d;
      sof0_q      <= sof0_d;
      eol0_q      <= eol0_d;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      v1_q        <= v0_q;
      sof1_q      <= sof0_q;
      eol1_q      <= eol0_q;
      mode1_q     <= mode_q;
      thr1_q      <= thr_q;
      out_valid_q <= v1_q;
      out_data_q  <= v1_q ? out_data_d : '0;
      out_sof_q   <= v1_q && sof1_q;
      out_eol_q   <= v1_q && eol1_q;
    end
  end

  // Line buffers are left uninitialised; border suppression hides stale data.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_old[col_cur] <= rd_new;
      lb_new[col_cur] <= strm.in_data;
    end
  end

  assign strm.in_ready  = en;
  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;
  assign strm.out_sof   = out_sof_q;
  assign strm.out_eol   = out_eol_q;
endmodule
